// File: rtl/extend_pkg.sv
// Shared encodings and widths for the vector immediate extender.
package extend_pkg;

  localparam int IMM_W = 26;

  typedef enum logic [2:0] {
    IMM_ZE16 = 3'b000,
    IMM_ZE26 = 3'b001,
    IMM_SE16 = 3'b010,
    IMM_ZE8  = 3'b011,
    IMM_SE8  = 3'b100,
    IMM_SE26 = 3'b101,
    IMM_REP8 = 3'b110,
    IMM_RSVD = 3'b111
  } imm_src_e;

  localparam imm_src_e IMM_SRC_RESERVED = IMM_RSVD;

endpackage

// File: rtl/vec_extend_pipe_if.sv
// Producer/consumer handshake bundle for vec_extend_pipe: decode side in, register-read side out.
interface vec_extend_pipe_if
  import extend_pkg::*;
#(
  parameter int N     = 32,
  parameter int LANES = 4
);

  logic                 in_valid;
  logic                 in_ready;
  logic [IMM_W-1:0]     A;
  logic [2:0]           ImmSrc;
  logic                 VecMode;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*N-1:0]   ExtImmV;
  logic                 err;

  modport master (
    output in_valid, A, ImmSrc, VecMode, out_ready,
    input  in_ready, out_valid, ExtImmV, err
  );

  modport slave (
    input  in_valid, A, ImmSrc, VecMode, out_ready,
    output in_ready, out_valid, ExtImmV, err
  );

endinterface

// File: rtl/extend_core.sv
// Combinational immediate extension: one N-bit lane value, placed in lane 0 or broadcast.
module extend_core
  import extend_pkg::*;
#(
  parameter int N     = 32,
  parameter int LANES = 4
) (
  input  logic [IMM_W-1:0]   a,
  input  imm_src_e           imm_src,
  input  logic               vec_mode,
  output logic [LANES*N-1:0] lanes,
  output logic               err
);

  logic [N-1:0] lane_val;

  always_comb begin
    lane_val = '0;
    err      = 1'b0;
    unique case (imm_src)
      IMM_ZE16:         lane_val = {{(N-16){1'b0}}, a[15:0]};
      IMM_ZE26:         lane_val = {{(N-IMM_W){1'b0}}, a};
      IMM_SE16:         lane_val = {{(N-16){a[15]}}, a[15:0]};
      IMM_ZE8:          lane_val = {{(N-8){1'b0}}, a[7:0]};
      IMM_SE8:          lane_val = {{(N-8){a[7]}}, a[7:0]};
      IMM_SE26:         lane_val = {{(N-IMM_W){a[IMM_W-1]}}, a};
      IMM_REP8:         lane_val = {(N/8){a[7:0]}};
      IMM_SRC_RESERVED: err      = 1'b1;
    endcase
  end

  // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    lanes = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i == 0 || vec_mode) lanes[i*N +: N] = lane_val;
    end
  end

endmodule

// File: rtl/vec_extend_pipe.sv
// Pipelined immediate extender: extends at the input and buffers results in a 2-entry ready/valid FIFO.
module vec_extend_pipe
  import extend_pkg::*;
#(
  parameter int N     = 32,
  parameter int LANES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  vec_extend_pipe_if.slave  bus
);

  localparam int DW = LANES * N;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] data;
  } entry_t;

  logic [DW-1:0] ext_lanes;
  logic          ext_err;

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  extend_core #(
    .N     (N),
    .LANES (LANES)
  ) u_core (
    .a        (bus.A),
    .imm_src  (imm_src_e'(bus.ImmSrc)),
    .vec_mode (bus.VecMode),
    .lanes    (ext_lanes),
    .err      (ext_err)
  );

  assign bus.in_ready  = (count_q < 2'd2) && rst;
  assign bus.out_valid = (count_q != 2'd0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  // Flush discards the whole queue and voids any push or pop offered in the same cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{err: ext_err, data: ext_lanes};
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the outputs below are forced to 0 whenever the queue is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.ExtImmV = bus.out_valid ? mem_q[rd_ptr_q].data : '0;
  assign bus.err     = bus.out_valid ? mem_q[rd_ptr_q].err  : 1'b0;

endmodule
